// File: rtl/btb_predictor_pkg.sv
// Shared encodings for the branch target buffer predictor: direction
// counter states, the counter values used at reset and on allocation,
// and the PREDICT_MODE selector values.
package btb_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = CTR_WNT;
    localparam ctr_t CTR_ALLOC = CTR_WT;

    localparam int MODE_ALWAYS_NT = 0;
    localparam int MODE_BTB       = 1;

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch-side lookup and resolve-side update signals between the pipeline
// (master) and the predictor (slave).
interface btb_predictor_if #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
);
    logic [WORD_SIZE-1:0] PC;
    logic [WORD_SIZE-1:0] Prediction;
    logic                 Hit;
    logic                 UpdateValid;
    logic [WORD_SIZE-1:0] UpdatePC;
    logic                 UpdateTaken;
    logic [WORD_SIZE-1:0] ActualBranchTarget;
    logic                 Correct;
    logic [CNT_WIDTH-1:0] MispredictCount;

    modport master (
        output PC, UpdateValid, UpdatePC, UpdateTaken, ActualBranchTarget, Correct,
        input  Prediction, Hit, MispredictCount
    );

    modport slave (
        input  PC, UpdateValid, UpdatePC, UpdateTaken, ActualBranchTarget, Correct,
        output Prediction, Hit, MispredictCount
    );
endinterface

// File: rtl/btb_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter2
    import btb_predictor_pkg::*;
(
    input  ctr_t i_ctr,
    input  logic i_taken,
    output ctr_t o_ctr
);

    // Step toward strongly-taken or strongly-not-taken, pinning at the ends.
    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) begin
                o_ctr = ctr_t'(i_ctr + 2'd1);
            end
        end else begin
            if (i_ctr != CTR_SNT) begin
                o_ctr = ctr_t'(i_ctr - 2'd1);
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per
// entry. Lookup is combinational on the fetch PC; updates from the resolve
// stage land on the clock edge and are seen by lookups one cycle later.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int INDEX_BITS   = 4,
    parameter int PREDICT_MODE = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic           clk,
    input  logic           reset,
    btb_predictor_if.slave bus
);

    localparam int ENTRIES  = 2 ** INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
    localparam logic BTB_ON = (PREDICT_MODE == MODE_BTB);

    logic                 r_valid  [ENTRIES];
    logic [TAG_BITS-1:0]  r_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] r_target [ENTRIES];
    ctr_t                 r_ctr    [ENTRIES];
    logic [CNT_WIDTH-1:0] r_missCount;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [WORD_SIZE-1:0]  w_pcPlusOne;
    logic                  w_hit;
    logic [INDEX_BITS-1:0] w_uIdx;
    logic [TAG_BITS-1:0]   w_uTag;
    logic                  w_uHit;
    logic                  w_tableWrite;
    ctr_t                  w_ctrNext;

    assign w_idx       = bus.PC[INDEX_BITS-1:0];
    assign w_tag       = bus.PC[WORD_SIZE-1:INDEX_BITS];
    assign w_pcPlusOne = bus.PC + WORD_SIZE'(1);
    assign w_hit       = BTB_ON && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign bus.Hit             = w_hit;
    assign bus.Prediction      = (w_hit && r_ctr[w_idx][1]) ? r_target[w_idx] : w_pcPlusOne;
    assign bus.MispredictCount = r_missCount;

    assign w_uIdx       = bus.UpdatePC[INDEX_BITS-1:0];
    assign w_uTag       = bus.UpdatePC[WORD_SIZE-1:INDEX_BITS];
    assign w_uHit       = r_valid[w_uIdx] && (r_tag[w_uIdx] == w_uTag);
    assign w_tableWrite = BTB_ON && bus.UpdateValid;

    sat_counter2 u_satCounter (
        .i_ctr   (r_ctr[w_uIdx]),
        .i_taken (bus.UpdateTaken),
        .o_ctr   (w_ctrNext)
    );

    // Valid bits and direction counters: cleared on reset, trained on a hit,
    // allocated weakly-taken when a taken branch misses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_RESET;
            end
        end else if (w_tableWrite) begin
            if (w_uHit) begin
                r_ctr[w_uIdx] <= w_ctrNext;
            end else if (bus.UpdateTaken) begin
                r_valid[w_uIdx] <= 1'b1;
                r_ctr[w_uIdx]   <= CTR_ALLOC;
            end
        end
    end

    // Tag and target storage carries no reset; any taken update rewrites both,
    // which leaves the tag unchanged on a hit and installs it on a miss.
    always_ff @(posedge clk) begin
        if (!reset && w_tableWrite && bus.UpdateTaken) begin
            r_tag[w_uIdx]    <= w_uTag;
            r_target[w_uIdx] <= bus.ActualBranchTarget;
        end
    end

    // Misprediction counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_missCount <= '0;
        end else if (bus.UpdateValid && !bus.Correct && (r_missCount != '1)) begin
            r_missCount <= r_missCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: three instances (BTB mode, BTB mode
// with a 4-bit miss counter, always-not-taken mode) share clock and reset.
module tb_btb_predictor;

    typedef struct packed {
        logic [1:0]  dut;
        logic        hit;
        logic [15:0] pred;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic reset;

    exp_t  expQ[$];
    string nameQ[$];
    int    testsRun;
    int    testsFailed;

    btb_predictor_if #(.WORD_SIZE(16), .CNT_WIDTH(16)) ifA ();
    btb_predictor_if #(.WORD_SIZE(16), .CNT_WIDTH(4))  ifB ();
    btb_predictor_if #(.WORD_SIZE(16), .CNT_WIDTH(16)) ifC ();

    btb_predictor #(.WORD_SIZE(16), .INDEX_BITS(4), .PREDICT_MODE(1), .CNT_WIDTH(16)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (ifA)
    );

    btb_predictor #(.WORD_SIZE(16), .INDEX_BITS(4), .PREDICT_MODE(1), .CNT_WIDTH(4)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (ifB)
    );

    btb_predictor #(.WORD_SIZE(16), .INDEX_BITS(4), .PREDICT_MODE(0), .CNT_WIDTH(16)) dutC (
        .clk   (clk),
        .reset (reset),
        .bus   (ifC)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's lookup and update inputs onto the chosen instance.
    task automatic applyStimulus(input int dut, input logic [15:0] pc, input logic uv,
                                 input logic [15:0] upc, input logic ut,
                                 input logic [15:0] tgt, input logic corr);
        case (dut)
            0: begin
                ifA.PC = pc; ifA.UpdateValid = uv; ifA.UpdatePC = upc;
                ifA.UpdateTaken = ut; ifA.ActualBranchTarget = tgt; ifA.Correct = corr;
            end
            1: begin
                ifB.PC = pc; ifB.UpdateValid = uv; ifB.UpdatePC = upc;
                ifB.UpdateTaken = ut; ifB.ActualBranchTarget = tgt; ifB.Correct = corr;
            end
            default: begin
                ifC.PC = pc; ifC.UpdateValid = uv; ifC.UpdatePC = upc;
                ifC.UpdateTaken = ut; ifC.ActualBranchTarget = tgt; ifC.Correct = corr;
            end
        endcase
    endtask

    // Queue the response expected from an instance in the current cycle.
    task automatic checkOutput(input string name, input int dut, input logic hit,
                               input logic [15:0] pred, input logic [15:0] cnt);
        exp_t e;
        e.dut  = 2'(dut);
        e.hit  = hit;
        e.pred = pred;
        e.cnt  = cnt;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    // Advance to just after the next rising edge and idle all update ports.
    task automatic step();
        @(posedge clk);
        #1;
        ifA.UpdateValid = 1'b0;
        ifB.UpdateValid = 1'b0;
        ifC.UpdateValid = 1'b0;
    endtask

    // Monitor: on each falling edge, compare every queued expectation with the
    // outputs the selected instance is presenting.
    always @(negedge clk) begin
        exp_t        e;
        string       n;
        logic        aHit;
        logic [15:0] aPred;
        logic [15:0] aCnt;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            case (e.dut)
                2'd0: begin aHit = ifA.Hit; aPred = ifA.Prediction; aCnt = ifA.MispredictCount; end
                2'd1: begin aHit = ifB.Hit; aPred = ifB.Prediction; aCnt = {12'h000, ifB.MispredictCount}; end
                default: begin aHit = ifC.Hit; aPred = ifC.Prediction; aCnt = ifC.MispredictCount; end
            endcase
            testsRun++;
            if (aHit !== e.hit || aPred !== e.pred || aCnt !== e.cnt) begin
                testsFailed++;
                $display("[TB] FAIL %s: got Hit=%0b Prediction=%h Count=%h, expected Hit=%0b Prediction=%h Count=%h",
                         n, aHit, aPred, aCnt, e.hit, e.pred, e.cnt);
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        applyStimulus(0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        applyStimulus(2, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        step();
        step();
        reset = 1'b0;

        applyStimulus(0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("resetPc0000", 0, 1'b0, 16'h0001, 16'h0000);
        step();
        applyStimulus(0, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("resetPc0010", 0, 1'b0, 16'h0011, 16'h0000);
        step();
        applyStimulus(0, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("resetPcWrap", 0, 1'b0, 16'h0000, 16'h0000);
        step();

        applyStimulus(0, 16'h0023, 1'b1, 16'h0023, 1'b1, 16'h0040, 1'b0);
        checkOutput("allocSameCycle", 0, 1'b0, 16'h0024, 16'h0000);
        step();
        applyStimulus(0, 16'h0023, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("allocNextCycle", 0, 1'b1, 16'h0040, 16'h0001);
        step();

        applyStimulus(0, 16'h0023, 1'b1, 16'h0023, 1'b0, 16'h0000, 1'b1);
        checkOutput("noBypass", 0, 1'b1, 16'h0040, 16'h0001);
        step();
        applyStimulus(0, 16'h0023, 1'b1, 16'h0023, 1'b1, 16'h0040, 1'b1);
        checkOutput("ctrWeakNt", 0, 1'b1, 16'h0024, 16'h0001);
        step();
        applyStimulus(0, 16'h0023, 1'b1, 16'h0023, 1'b1, 16'h0040, 1'b1);
        checkOutput("ctrWeakT", 0, 1'b1, 16'h0040, 16'h0001);
        step();
        applyStimulus(0, 16'h0023, 1'b1, 16'h0023, 1'b0, 16'h0000, 1'b1);
        checkOutput("ctrStrongT", 0, 1'b1, 16'h0040, 16'h0001);
        step();
        applyStimulus(0, 16'h0023, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("hysteresis", 0, 1'b1, 16'h0040, 16'h0001);
        step();

        applyStimulus(0, 16'h0023, 1'b1, 16'h1023, 1'b1, 16'h2000, 1'b0);
        checkOutput("aliasBefore", 0, 1'b1, 16'h0040, 16'h0001);
        step();
        applyStimulus(0, 16'h0023, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("aliasEvicted", 0, 1'b0, 16'h0024, 16'h0002);
        step();
        applyStimulus(0, 16'h1023, 1'b1, 16'h0053, 1'b0, 16'h0000, 1'b1);
        checkOutput("aliasNewEntry", 0, 1'b1, 16'h2000, 16'h0002);
        step();
        applyStimulus(0, 16'h1023, 1'b1, 16'h1023, 1'b1, 16'h3000, 1'b1);
        checkOutput("ntMissNoChange", 0, 1'b1, 16'h2000, 16'h0002);
        step();
        applyStimulus(0, 16'h1023, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("targetRetrain", 0, 1'b1, 16'h3000, 16'h0002);
        step();
        applyStimulus(0, 16'h0053, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("ntMissNoAlloc", 0, 1'b0, 16'h0054, 16'h0002);
        step();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 16'h0100, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0);
            checkOutput("satCount", 1, 1'b0, 16'h0101, (i > 15) ? 16'h000F : 16'(i));
            step();
        end
        applyStimulus(1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("satCountFinal", 1, 1'b0, 16'h0101, 16'h000F);
        step();

        applyStimulus(2, 16'h0023, 1'b1, 16'h0023, 1'b1, 16'h0040, 1'b0);
        checkOutput("mode0SameCycle", 2, 1'b0, 16'h0024, 16'h0000);
        step();
        applyStimulus(2, 16'h0023, 1'b1, 16'h0023, 1'b1, 16'h0040, 1'b0);
        checkOutput("mode0NoWrite", 2, 1'b0, 16'h0024, 16'h0001);
        step();
        applyStimulus(2, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("mode0CountWrap", 2, 1'b0, 16'h0000, 16'h0002);
        step();

        applyStimulus(0, 16'h1023, 1'b1, 16'h0033, 1'b1, 16'h5000, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(0, 16'h1023, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("resetClearsEntry", 0, 1'b0, 16'h1024, 16'h0000);
        checkOutput("resetClearsSatCnt", 1, 1'b0, 16'h0101, 16'h0000);
        checkOutput("resetClearsMode0Cnt", 2, 1'b0, 16'h0000, 16'h0000);
        step();
        applyStimulus(0, 16'h0033, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("resetDropsUpdate", 0, 1'b0, 16'h0034, 16'h0000);
        step();

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
